// File: rtl/rs_age_sel.sv
// rs_age_sel: parametrised reservation station with CDB wakeup (resident
// and dispatch-cycle), synchronous squash and oldest-first issue selection.
//
// Optional feature macro: RS_AGE_ORDER_EN
//   defined   -> age matrix kept; each issue port picks the oldest candidate
//   undefined -> no age storage; each issue port picks the lowest-index candidate
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   squash              drop every entry (and this cycle's dispatch) at the next edge
//   dispatch_rs_pkts    DISP_W dispatch lanes, lane DISP_W-1 oldest
//   fu_fifo_stall       per-class FU FIFO stall
//   cdb_tags/cdb_valid  CDB_W broadcast tags
//   rsb_sq_ready_flags  per store-queue-slot ready, indexed by sq_tail
//   rsb_issue_packets   ISSUE_W issued entries (combinational), port 0 oldest
//   rsb_struct_halt     per-lane structural stall
//   rsb_free_cnt        number of invalid entries in registered state

package rs_age_sel_pkg;
  localparam int unsigned RS_PR_W     = 6;
  localparam int unsigned RS_SQ_DEPTH = 8;
  localparam int unsigned RS_SQ_IDX_W = $clog2(RS_SQ_DEPTH);

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_LS     = 3'd1,
    FU_MULT   = 3'd2,
    FU_BRANCH = 3'd3
  } fu_sel_e;

  typedef struct packed {
    logic                   valid;
    fu_sel_e                dec_fu_unit_sel;
    logic [RS_PR_W-1:0]     src1_pr;
    logic                   src1_rdy;
    logic [RS_PR_W-1:0]     src2_pr;
    logic                   src2_rdy;
    logic [RS_PR_W-1:0]     dest_pr;
    logic [RS_SQ_IDX_W-1:0] sq_tail;
    logic [15:0]            pc;
  } RS_S_PACKET;

  typedef struct packed {
    logic alu;
    logic ls;
    logic mult;
    logic branch;
  } FU_FIFO_PACKET;
endpackage

module rs_age_sel
  import rs_age_sel_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned DISP_W   = 3,
  parameter int unsigned ISSUE_W  = 3,
  parameter int unsigned CDB_W    = 3,
  parameter int unsigned PR_W     = RS_PR_W,
  parameter int unsigned SQ_DEPTH = RS_SQ_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            squash,
  input  RS_S_PACKET [DISP_W-1:0]         dispatch_rs_pkts,
  input  FU_FIFO_PACKET                   fu_fifo_stall,
  input  logic [CDB_W-1:0][PR_W-1:0]      cdb_tags,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [SQ_DEPTH-1:0]             rsb_sq_ready_flags,
  output RS_S_PACKET [ISSUE_W-1:0]        rsb_issue_packets,
  output logic [DISP_W-1:0]               rsb_struct_halt,
  output logic [$clog2(RS_DEPTH+1)-1:0]   rsb_free_cnt
);

  localparam int unsigned CNT_W  = $clog2(RS_DEPTH+1);
  localparam int unsigned LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  RS_S_PACKET          ents [RS_DEPTH];
`ifdef RS_AGE_ORDER_EN
  // age[i][j] = 1 when entry i is older than entry j
  logic [RS_DEPTH-1:0] age  [RS_DEPTH];
`endif

  RS_S_PACKET          lane_pkt  [DISP_W];
  logic [LANE_W-1:0]   alloc_lane [RS_DEPTH];
  logic [RS_DEPTH-1:0] alloc_en;
  logic [RS_DEPTH-1:0] rdy1_nx, rdy2_nx, issuable, grant;
  logic [CNT_W-1:0]    free_cnt;

  // Dispatch lanes with same-cycle CDB wakeup folded into their rdy bits
  always_comb begin
    for (int unsigned l = 0; l < DISP_W; l++) begin
      lane_pkt[l] = dispatch_rs_pkts[l];
      for (int unsigned c = 0; c < CDB_W; c++) begin
        if (cdb_valid[c] && (cdb_tags[c] == dispatch_rs_pkts[l].src1_pr))
          lane_pkt[l].src1_rdy = 1'b1;
        if (cdb_valid[c] && (cdb_tags[c] == dispatch_rs_pkts[l].src2_pr))
          lane_pkt[l].src2_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int unsigned k = 0; k < RS_DEPTH; k++)
      if (!ents[k].valid) free_cnt = free_cnt + CNT_W'(1);
  end

  assign rsb_free_cnt = free_cnt;

  always_comb begin
    rsb_struct_halt = '0;
    for (int unsigned i = 0; i < DISP_W; i++)
      rsb_struct_halt[i] = (free_cnt < CNT_W'(DISP_W - i));
  end

  // The n-th free slot (lowest index first) belongs to lane DISP_W-1-n.
  // An invalid lane keeps its slot reservation but writes nothing.
  always_comb begin
    int unsigned seen;
    seen     = 0;
    alloc_en = '0;
    for (int unsigned k = 0; k < RS_DEPTH; k++) begin
      alloc_lane[k] = '0;
      if (!ents[k].valid) begin
        if (seen < DISP_W) begin
          alloc_lane[k] = LANE_W'(DISP_W - 1 - seen);
          alloc_en[k]   = dispatch_rs_pkts[DISP_W - 1 - seen].valid & ~squash;
        end
        seen = seen + 1;
      end
    end
  end

  // Resident wakeup and issue eligibility
  always_comb begin
    logic hit1, hit2, fu_ok;
    hit1     = 1'b0;
    hit2     = 1'b0;
    fu_ok    = 1'b0;
    rdy1_nx  = '0;
    rdy2_nx  = '0;
    issuable = '0;
    for (int unsigned k = 0; k < RS_DEPTH; k++) begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int unsigned c = 0; c < CDB_W; c++) begin
        if (cdb_valid[c] && (cdb_tags[c] == ents[k].src1_pr)) hit1 = 1'b1;
        if (cdb_valid[c] && (cdb_tags[c] == ents[k].src2_pr)) hit2 = 1'b1;
      end
      rdy1_nx[k] = ents[k].src1_rdy | hit1;
      rdy2_nx[k] = ents[k].src2_rdy | hit2;
      case (ents[k].dec_fu_unit_sel)
        FU_ALU:    fu_ok = ~fu_fifo_stall.alu;
        FU_LS:     fu_ok = ~fu_fifo_stall.ls;
        FU_MULT:   fu_ok = ~fu_fifo_stall.mult;
        FU_BRANCH: fu_ok = ~fu_fifo_stall.branch;
        default:   fu_ok = 1'b0;
      endcase
      issuable[k] = ents[k].valid & rdy1_nx[k] & rdy2_nx[k] &
                    rsb_sq_ready_flags[ents[k].sq_tail] & fu_ok;
    end
  end

  // Ports fill in turn; each removes its pick from the candidate set so
  // the next port sees the next-oldest (or next-lowest) entry.
  always_comb begin
    logic [RS_DEPTH-1:0] cand;
    logic                found;
    logic                blocked;
    cand              = issuable;
    found             = 1'b0;
    blocked           = 1'b0;
    grant             = '0;
    rsb_issue_packets = '0;
    for (int unsigned p = 0; p < ISSUE_W; p++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < RS_DEPTH; k++) begin
        blocked = 1'b0;
`ifdef RS_AGE_ORDER_EN
        for (int unsigned j = 0; j < RS_DEPTH; j++)
          if (cand[j] && age[j][k]) blocked = 1'b1;
`endif
        if (!found && cand[k] && !blocked) begin
          found   = 1'b1;
          cand[k] = 1'b0;
          if (!squash) begin
            rsb_issue_packets[p]          = ents[k];
            rsb_issue_packets[p].valid    = 1'b1;
            rsb_issue_packets[p].src1_rdy = rdy1_nx[k];
            rsb_issue_packets[p].src2_rdy = rdy2_nx[k];
            grant[k]                      = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < RS_DEPTH; k++) ents[k] <= '0;
    end else if (squash) begin
      for (int unsigned k = 0; k < RS_DEPTH; k++) ents[k].valid <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < RS_DEPTH; k++) begin
        if (alloc_en[k]) begin
          ents[k] <= lane_pkt[alloc_lane[k]];
        end else if (grant[k]) begin
          ents[k].valid <= 1'b0;
        end else begin
          ents[k].src1_rdy <= rdy1_nx[k];
          ents[k].src2_rdy <= rdy2_nx[k];
        end
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Row clears come first so that a same-cycle older lane's column set
  // (later in the block) wins for the pair of new slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) age[i] <= '0;
    end else if (squash) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) age[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < RS_DEPTH; k++)
        if (alloc_en[k]) age[k] <= '0;
      for (int unsigned k = 0; k < RS_DEPTH; k++) begin
        if (alloc_en[k]) begin
          for (int unsigned j = 0; j < RS_DEPTH; j++)
            if (ents[j].valid || (alloc_en[j] && (alloc_lane[j] > alloc_lane[k])))
              age[j][k] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_age_sel.sv
module tb_rs_age_sel;
  import rs_age_sel_pkg::*;

  localparam int unsigned DISP_W  = 3;
  localparam int unsigned ISSUE_W = 3;
  localparam int unsigned CDB_W   = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        squash;
  RS_S_PACKET [DISP_W-1:0]     disp;
  FU_FIFO_PACKET               stall;
  logic [CDB_W-1:0][5:0]       cdb_tags;
  logic [CDB_W-1:0]            cdb_valid;
  logic [7:0]                  sq_flags;

  RS_S_PACKET [ISSUE_W-1:0]    iss;
  logic [DISP_W-1:0]           halt;
  logic [4:0]                  free_cnt;

  RS_S_PACKET [0:0]            iss1;
  logic [DISP_W-1:0]           halt1;
  logic [4:0]                  free1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_age_sel dut (
    .clk(clk), .rst(rst), .squash(squash),
    .dispatch_rs_pkts(disp), .fu_fifo_stall(stall),
    .cdb_tags(cdb_tags), .cdb_valid(cdb_valid),
    .rsb_sq_ready_flags(sq_flags),
    .rsb_issue_packets(iss), .rsb_struct_halt(halt), .rsb_free_cnt(free_cnt)
  );

  rs_age_sel #(.ISSUE_W(1)) dut1 (
    .clk(clk), .rst(rst), .squash(squash),
    .dispatch_rs_pkts(disp), .fu_fifo_stall(stall),
    .cdb_tags(cdb_tags), .cdb_valid(cdb_valid),
    .rsb_sq_ready_flags(sq_flags),
    .rsb_issue_packets(iss1), .rsb_struct_halt(halt1), .rsb_free_cnt(free1)
  );

  function automatic RS_S_PACKET mk(input logic [15:0] pc, input fu_sel_e fu,
                                    input logic [5:0] s1, input logic r1,
                                    input logic [5:0] s2, input logic r2,
                                    input logic [2:0] sq);
    RS_S_PACKET p;
    p                 = '0;
    p.valid           = 1'b1;
    p.dec_fu_unit_sel = fu;
    p.src1_pr         = s1;
    p.src1_rdy        = r1;
    p.src2_pr         = s2;
    p.src2_rdy        = r2;
    p.dest_pr         = 6'h30;
    p.sq_tail         = sq;
    p.pc              = pc;
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    squash    = 1'b0;
    disp      = '0;
    stall     = '0;
    cdb_tags  = '0;
    cdb_valid = '0;
    sq_flags  = '1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (free_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_free: got %0d expected 16", free_cnt); end
    n_checks++;
    if (halt !== 3'b000) begin n_fail++; $display("FAIL reset_halt: got %b expected 000", halt); end
    n_checks++;
    if (iss !== '0) begin n_fail++; $display("FAIL reset_issue: got %h expected 0", iss); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    disp[2] = mk(16'h102, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[1] = mk(16'h101, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[0] = mk(16'h100, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    #2;
    n_checks++;
    if ({iss[2].valid, iss[1].valid, iss[0].valid} !== 3'b000) begin
      n_fail++; $display("FAIL basic_no_same_cycle_issue: got %b expected 000",
                         {iss[2].valid, iss[1].valid, iss[0].valid});
    end
    tick();
    disp = '0;
    #2;
    n_checks++;
    if (free_cnt !== 5'd13) begin n_fail++; $display("FAIL basic_free: got %0d expected 13", free_cnt); end
    n_checks++;
    if ({iss[0].valid, iss[0].pc} !== {1'b1, 16'h102}) begin
      n_fail++; $display("FAIL basic_port0: got %b/%h expected 1/0102", iss[0].valid, iss[0].pc);
    end
    n_checks++;
    if ({iss[1].valid, iss[1].pc} !== {1'b1, 16'h101}) begin
      n_fail++; $display("FAIL basic_port1: got %b/%h expected 1/0101", iss[1].valid, iss[1].pc);
    end
    n_checks++;
    if ({iss[2].valid, iss[2].pc} !== {1'b1, 16'h100}) begin
      n_fail++; $display("FAIL basic_port2: got %b/%h expected 1/0100", iss[2].valid, iss[2].pc);
    end
    tick();
    #2;
    n_checks++;
    if (free_cnt !== 5'd16) begin n_fail++; $display("FAIL basic_free_back: got %0d expected 16", free_cnt); end
    n_checks++;
    if ({iss[2].valid, iss[1].valid, iss[0].valid} !== 3'b000) begin
      n_fail++; $display("FAIL basic_drained: got %b expected 000",
                         {iss[2].valid, iss[1].valid, iss[0].valid});
    end
  endtask

  task automatic test_halt;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < 3; l++)
        disp[l] = mk(16'(16'h300 + c * 3 + l), FU_ALU, 6'h3F, 1'b0, 6'h02, 1'b1, 3'd0);
      tick();
    end
    disp = '0;
    #2;
    n_checks++;
    if ({free_cnt, halt} !== {5'd4, 3'b000}) begin
      n_fail++; $display("FAIL halt_12: got free %0d halt %b expected 4/000", free_cnt, halt);
    end
    disp[2] = mk(16'h310, FU_ALU, 6'h3F, 1'b0, 6'h02, 1'b1, 3'd0);
    disp[1] = mk(16'h311, FU_ALU, 6'h3F, 1'b0, 6'h02, 1'b1, 3'd0);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if ({free_cnt, halt} !== {5'd2, 3'b001}) begin
      n_fail++; $display("FAIL halt_14: got free %0d halt %b expected 2/001", free_cnt, halt);
    end
    for (int l = 0; l < 3; l++)
      disp[l] = mk(16'(16'h320 + l), FU_ALU, 6'h3F, 1'b0, 6'h02, 1'b1, 3'd0);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if ({free_cnt, halt} !== {5'd0, 3'b111}) begin
      n_fail++; $display("FAIL halt_16: got free %0d halt %b expected 0/111", free_cnt, halt);
    end
    for (int l = 0; l < 3; l++)
      disp[l] = mk(16'(16'h330 + l), FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if ({free_cnt, iss[0].valid} !== {5'd0, 1'b0}) begin
      n_fail++; $display("FAIL halt_no_alloc: got free %0d iss0 %b expected 0/0", free_cnt, iss[0].valid);
    end
    squash = 1'b1;
    tick();
    squash = 1'b0;
    #2;
    n_checks++;
    if (free_cnt !== 5'd16) begin n_fail++; $display("FAIL halt_cleanup: got %0d expected 16", free_cnt); end
  endtask

  task automatic test_squash;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < 3; l++)
        if (c < 3 || l == 2)
          disp[l] = mk(16'(16'h600 + c * 3 + l), FU_ALU, 6'h3E, 1'b0, 6'h02, 1'b1, 3'd0);
      tick();
      disp = '0;
    end
    #2;
    n_checks++;
    if (free_cnt !== 5'd6) begin n_fail++; $display("FAIL squash_fill: got %0d expected 6", free_cnt); end
    squash       = 1'b1;
    cdb_tags[0]  = 6'h3E;
    cdb_valid    = 3'b001;
    for (int l = 0; l < 3; l++)
      disp[l] = mk(16'(16'h680 + l), FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    #2;
    n_checks++;
    if ({iss[2].valid, iss[1].valid, iss[0].valid} !== 3'b000) begin
      n_fail++; $display("FAIL squash_issue_forced: got %b expected 000",
                         {iss[2].valid, iss[1].valid, iss[0].valid});
    end
    tick();
    squash    = 1'b0;
    cdb_valid = '0;
    disp      = '0;
    #2;
    n_checks++;
    if ({free_cnt, iss[0].valid} !== {5'd16, 1'b0}) begin
      n_fail++; $display("FAIL squash_after: got free %0d iss0 %b expected 16/0", free_cnt, iss[0].valid);
    end
  endtask

  task automatic test_cdb_wakeup;
    disp[2] = mk(16'h400, FU_ALU, 6'h21, 1'b0, 6'h05, 1'b1, 3'd0);
    tick();
    disp        = '0;
    cdb_tags[0] = 6'h21;
    cdb_tags[1] = 6'h22;
    cdb_valid   = 3'b010;
    #2;
    n_checks++;
    if (iss[0].valid !== 1'b0) begin n_fail++; $display("FAIL cdb_no_wake: got %b expected 0", iss[0].valid); end
    tick();
    cdb_tags[0] = 6'h00;
    cdb_tags[1] = 6'h21;
    cdb_valid   = 3'b010;
    disp[2]     = mk(16'h401, FU_ALU, 6'h21, 1'b0, 6'h05, 1'b1, 3'd0);
    #2;
    n_checks++;
    if ({iss[0].valid, iss[0].pc, iss[1].valid} !== {1'b1, 16'h400, 1'b0}) begin
      n_fail++; $display("FAIL cdb_same_cycle: got %b/%h/%b expected 1/0400/0",
                         iss[0].valid, iss[0].pc, iss[1].valid);
    end
    tick();
    cdb_valid = '0;
    disp      = '0;
    #2;
    n_checks++;
    if ({iss[0].valid, iss[0].pc, iss[0].src1_rdy, free_cnt} !== {1'b1, 16'h401, 1'b1, 5'd15}) begin
      n_fail++; $display("FAIL cdb_dispatch_wake: got %b/%h/%b/%0d expected 1/0401/1/15",
                         iss[0].valid, iss[0].pc, iss[0].src1_rdy, free_cnt);
    end
    tick();
    #2;
    n_checks++;
    if (free_cnt !== 5'd16) begin n_fail++; $display("FAIL cdb_drain: got %0d expected 16", free_cnt); end
  endtask

  task automatic test_stall;
    stall.mult = 1'b1;
    disp[2]    = mk(16'h500, FU_MULT, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if (iss[0].valid !== 1'b0) begin n_fail++; $display("FAIL stall_mult: got %b expected 0", iss[0].valid); end
    stall     = '0;
    stall.alu = 1'b1;
    #2;
    n_checks++;
    if ({iss[0].valid, iss[0].pc} !== {1'b1, 16'h500}) begin
      n_fail++; $display("FAIL stall_release: got %b/%h expected 1/0500", iss[0].valid, iss[0].pc);
    end
    tick();
    stall       = '0;
    sq_flags[5] = 1'b0;
    disp[2]     = mk(16'h501, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd5);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if (iss[0].valid !== 1'b0) begin n_fail++; $display("FAIL stall_sq: got %b expected 0", iss[0].valid); end
    sq_flags[5] = 1'b1;
    #2;
    n_checks++;
    if ({iss[0].valid, iss[0].pc} !== {1'b1, 16'h501}) begin
      n_fail++; $display("FAIL stall_sq_release: got %b/%h expected 1/0501", iss[0].valid, iss[0].pc);
    end
    tick();
    disp[2] = mk(16'h502, fu_sel_e'(3'd6), 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    tick();
    disp = '0;
    #2;
    n_checks++;
    if ({iss[0].valid, free_cnt} !== {1'b0, 5'd15}) begin
      n_fail++; $display("FAIL stall_unknown_fu: got %b/%0d expected 0/15", iss[0].valid, free_cnt);
    end
    squash = 1'b1;
    tick();
    squash = 1'b0;
  endtask

  task automatic test_age;
    int w;
    squash = 1'b1;
    tick();
    squash  = 1'b0;
    disp[2] = mk(16'h200, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[1] = mk(16'h201, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[0] = mk(16'h202, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    tick();
    disp[2] = mk(16'h203, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[1] = mk(16'h204, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    disp[0] = mk(16'h205, FU_ALU, 6'h15, 1'b0, 6'h02, 1'b1, 3'd0);
    #2;
    n_checks++;
    if ({iss1[0].valid, iss1[0].pc} !== {1'b1, 16'h200}) begin
      n_fail++; $display("FAIL age_first: got %b/%h expected 1/0200", iss1[0].valid, iss1[0].pc);
    end
    tick();
    disp = '0;
    w    = 0;
    while (free1 !== 5'd15 && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (free1 !== 5'd15) begin n_fail++; $display("FAIL age_drain: got %0d expected 15", free1); end
    disp[2] = mk(16'h206, FU_ALU, 6'h01, 1'b1, 6'h02, 1'b1, 3'd0);
    tick();
    disp        = '0;
    cdb_tags[0] = 6'h15;
    cdb_valid   = 3'b001;
    #2;
    n_checks++;
`ifdef RS_AGE_ORDER_EN
    if ({iss1[0].valid, iss1[0].pc} !== {1'b1, 16'h205}) begin
      n_fail++; $display("FAIL age_pick: got %b/%h expected 1/0205", iss1[0].valid, iss1[0].pc);
    end
`else
    if ({iss1[0].valid, iss1[0].pc} !== {1'b1, 16'h206}) begin
      n_fail++; $display("FAIL age_pick: got %b/%h expected 1/0206", iss1[0].valid, iss1[0].pc);
    end
`endif
    tick();
    cdb_valid = '0;
    #2;
    n_checks++;
`ifdef RS_AGE_ORDER_EN
    if ({iss1[0].valid, iss1[0].pc} !== {1'b1, 16'h206}) begin
      n_fail++; $display("FAIL age_second: got %b/%h expected 1/0206", iss1[0].valid, iss1[0].pc);
    end
`else
    if ({iss1[0].valid, iss1[0].pc} !== {1'b1, 16'h205}) begin
      n_fail++; $display("FAIL age_second: got %b/%h expected 1/0205", iss1[0].valid, iss1[0].pc);
    end
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_squash();
    test_cdb_wakeup();
    test_stall();
    test_age();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_age_sel.md
# rs_age_sel

Parametrised reservation station: the successor to the fixed 16-entry, 3-wide RS. Depth, dispatch width, issue width and CDB width are all parameters. Adds dispatch-cycle CDB wakeup, a synchronous squash, and oldest-first issue selection through an age matrix. It sits between dispatch (RS_S_PACKET lanes, LSQ readiness) and the FU FIFOs, and it snoops the CDB.

## Interface
- RS_DEPTH, 16, number of entries; must be ≥ DISP_W.
- DISP_W, 3, dispatch lanes. Lane DISP_W-1 is oldest in program order.
- ISSUE_W, 3, issue ports. Port 0 carries the oldest selected entry.
- CDB_W, 3, CDB tags per cycle.
- PR_W, 6, physical register tag width.
- SQ_DEPTH, 8, store queue entries; indexed by RS_S_PACKET.sq_tail.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- squash  in  1  flush all entries at the next edge.
- dispatch_rs_pkts  in  DISP_W×RS_S_PACKET  dispatch lanes; .valid qualifies each lane.
- fu_fifo_stall  in  FU_FIFO_PACKET  per-class FU FIFO stall (alu/ls/mult/branch).
- cdb_tags  in  CDB_W×PR_W  broadcast tags.
- cdb_valid  in  CDB_W  per-tag valid.
- rsb_sq_ready_flags  in  SQ_DEPTH  per store-queue-slot ready.
- rsb_issue_packets  out  ISSUE_W×RS_S_PACKET  issued entries; .valid = port fires.
- rsb_struct_halt  out  DISP_W  per-lane structural stall.
- rsb_free_cnt  out  $clog2(RS_DEPTH+1)  count of invalid entries (registered state).

## Operation
- Free slots = entries with valid==0 in registered state. Slots freed by issue this cycle are not reusable until the next cycle.
- Allocation order: lane DISP_W-1 takes the lowest-index free slot, then lane DISP_W-2 takes the next, and so on.
- rsb_struct_halt[i] = (rsb_free_cnt < DISP_W-i). This is combinational on registered state and independent of lane valid.
- A lane whose .valid is 0 allocates nothing but still consumes its priority position.
- Dispatch wakeup: if a dispatched source tag matches any valid CDB tag in the same cycle, the stored rdy bit is written as 1.
- Resident wakeup: src{1,2}_rdy_next = stored rdy OR match against any valid cdb tag. Ready bits are stored at the edge.
- Entry issuable iff all of the following hold:
  - valid;
  - rdy1_next & rdy2_next;
  - rsb_sq_ready_flags[sq_tail];
  - FU class not stalled. Unknown dec_fu_unit_sel → not issuable.
- Age matrix age[i][j] (i older than j) on allocate of slot k:
  - set age[j][k]=1 for every currently valid j and for every slot allocated by an older lane in the same cycle;
  - set age[k][j]=0 for all j.
- Selection, ports 0..ISSUE_W-1 in turn: pick the issuable, not-yet-granted entry with no issuable, not-yet-granted older entry. A port with no candidate drives an all-zero packet.
- Granted entries go valid=0 at the next edge. Non-granted entries hold their payload and update rdy bits.
- squash:
  - all entries valid=0 at the next edge;
  - that cycle's dispatch is dropped;
  - issue port valids forced 0 in the squash cycle;
  - age matrix cleared.
- rst (async): all entries zero, age matrix zero, rsb_free_cnt=RS_DEPTH, rsb_struct_halt=0, all issue packets zero.

## Timing
- Dispatch in cycle N; the entry is eligible to issue in cycle N+1 at the earliest.
- CDB tag in cycle N wakes a resident entry for issue in cycle N. The issue path is combinational from the registered entries plus the CDB.
- rsb_issue_packets is combinational. A grant in cycle N frees the slot at the N→N+1 edge, and rsb_free_cnt rises in N+1.
- Simultaneous dispatch-allocate and issue never target the same slot, because allocation uses only invalid slots.
- squash takes priority over dispatch and issue in the same cycle.
- rst deassertion mid-stream: first operational edge starts from the empty state.

## Configuration
- RS_AGE_ORDER_EN defined: age matrix built and selection is oldest-first as above.
- RS_AGE_ORDER_EN undefined: no age matrix storage; selection is lowest-index-first per port. All other behaviour is identical.

## Test plan
- Reset, then dispatch 3 ALU ops with ready sources in one cycle → slots 0,1,2 filled; all 3 issue next cycle on ports 0,1,2 in lane order 2,1,0; rsb_free_cnt returns to 16.
- Fill to 14 entries → rsb_struct_halt=3'b001. Fill to 16 → halt=3'b111, and dispatch while halted allocates nothing.
- Entry waiting on tag 0x21, cdb_tags[1]=0x21 with cdb_valid[1]=1 → issues that same cycle. Also dispatch an op with src1=0x21 in that cycle → its stored rdy1=1, and it issues next cycle.
- With RS_AGE_ORDER_EN: an old entry sits in slot 5 and a younger ready entry in slot 0, both ready at once with ISSUE_W=1 → slot 5 issues first. Without the macro → slot 0 issues first.
- fu_fifo_stall.mult=1 with a ready MULT entry → no issue. Deassert → it issues. sq flag 0 for its sq_tail likewise blocks issue.
- 10 valid entries, squash=1 with 3 dispatching lanes → issue valids 0 that cycle; next cycle free_cnt=16 and no entry issues.
